// File: rtl/dacx0004_spi_receiver.sv
// dacx0004_spi_receiver: SPI responder modelling the DACx0004 register behaviour.
// Receives 32-bit frames (MSB first, sampled on SCK fall), decodes write/update
// commands into per-channel input and DAC registers, and applies nLDAC.
// Ports:
//   clk100mhz         system clock
//   rst               synchronous active-high reset
//   i_sck/i_cs/i_sdi  SPI pins (asynchronous)
//   i_nldac           load DAC, active low (asynchronous)
//   or16_dac_ch0..3   DAC register per channel
//   or_frame_valid    one-cycle pulse on an accepted 32-bit frame
//   or32_frame        last accepted raw frame
//   or_frame_error    one-cycle pulse when CS rose with bit count != 32
//   or16_frame_count  accepted-frame counter (wraps)
module dacx0004_spi_receiver (
  input  logic        clk100mhz,
  input  logic        rst,
  input  logic        i_sck,
  input  logic        i_cs,
  input  logic        i_sdi,
  input  logic        i_nldac,
  output logic [15:0] or16_dac_ch0,
  output logic [15:0] or16_dac_ch1,
  output logic [15:0] or16_dac_ch2,
  output logic [15:0] or16_dac_ch3,
  output logic        or_frame_valid,
  output logic [31:0] or32_frame,
  output logic        or_frame_error,
  output logic [15:0] or16_frame_count
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e state_q, state_d;

  logic [1:0] sck_sync_q, cs_sync_q, sdi_sync_q, nldac_sync_q;
  logic       sck_hist_q, cs_hist_q, nldac_hist_q;
  logic [1:0] flush_q;
  logic       cs_armed_q;
  logic       ldac_q;

  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] frame_q, frame_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_valid_q, frame_error_q;
  logic [3:0][15:0] in_q, in_d, dac_q, dac_d;

  logic sck_fall, cs_fall, cs_rise, nldac_fall;
  logic frame_start, shift_en, frame_err, commit;
  logic [3:0]  cmd, addr, ch_mask;
  logic [15:0] data;

  // Input conditioning: 2-FF synchronizers plus one history stage for edges.
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      sck_sync_q   <= 2'b11;
      cs_sync_q    <= 2'b11;
      nldac_sync_q <= 2'b11;
      sdi_sync_q   <= 2'b00;
      sck_hist_q   <= 1'b1;
      cs_hist_q    <= 1'b1;
      nldac_hist_q <= 1'b1;
      flush_q      <= 2'b00;
      cs_armed_q   <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[0], i_sck};
      cs_sync_q    <= {cs_sync_q[0], i_cs};
      nldac_sync_q <= {nldac_sync_q[0], i_nldac};
      sdi_sync_q   <= {sdi_sync_q[0], i_sdi};
      sck_hist_q   <= sck_sync_q[1];
      cs_hist_q    <= cs_sync_q[1];
      nldac_hist_q <= nldac_sync_q[1];
      flush_q      <= {flush_q[0], 1'b1};
      // Only arm frame starts once CS has been seen high on real pin samples,
      // so a CS that was already low during reset is not mistaken for a fall.
      cs_armed_q   <= cs_armed_q | (flush_q[1] & cs_sync_q[1]);
    end
  end

  assign sck_fall   = sck_hist_q & ~sck_sync_q[1];
  assign cs_fall    = cs_hist_q & ~cs_sync_q[1] & cs_armed_q;
  assign cs_rise    = ~cs_hist_q & cs_sync_q[1];
  assign nldac_fall = nldac_hist_q & ~nldac_sync_q[1];

  // FSM state register
  always_ff @(posedge clk100mhz) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StShift;
      StShift:  if (cs_rise) state_d = (bit_cnt_q == 6'd32) ? StCommit : StIdle;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_start = (state_q == StIdle) && cs_fall;
    shift_en    = (state_q == StShift) && sck_fall;
    frame_err   = (state_q == StShift) && cs_rise && (bit_cnt_q != 6'd32);
    commit      = (state_q == StCommit);
  end

  // Shift register and saturating bit counter
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (frame_start) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d   = {shift_q[30:0], sdi_sync_q[1]};
      bit_cnt_d = (bit_cnt_q == 6'd33) ? 6'd33 : bit_cnt_q + 6'd1;
    end
  end

  assign cmd  = shift_q[27:24];
  assign addr = shift_q[23:20];
  assign data = shift_q[19:4];

  always_comb begin
    ch_mask = 4'b0000;
    if (addr == 4'hF)      ch_mask = 4'hF;
    else if (addr < 4'd4)  ch_mask = 4'b0001 << addr[1:0];
  end

  // Register file update; the nLDAC copy sees post-commit input values.
  always_comb begin
    in_d          = in_q;
    dac_d         = dac_q;
    frame_d       = frame_q;
    frame_count_d = frame_count_q;
    if (commit) begin
      frame_d       = shift_q;
      frame_count_d = frame_count_q + 16'd1;
      for (int i = 0; i < 4; i++) begin
        if (ch_mask[i]) begin
          case (cmd)
            4'h0, 4'h2: in_d[i] = data;
            4'h1:       dac_d[i] = in_q[i];
            4'h3: begin
              in_d[i]  = data;
              dac_d[i] = data;
            end
            default: ;
          endcase
        end
      end
      if (cmd == 4'h2 && ch_mask != 4'b0000) dac_d = in_d;
    end
    if (ldac_q) dac_d = in_d;
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      in_q          <= '0;
      dac_q         <= '0;
      ldac_q        <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      frame_count_q <= frame_count_d;
      frame_valid_q <= commit;
      frame_error_q <= frame_err;
      in_q          <= in_d;
      dac_q         <= dac_d;
      // Extra stage aligns the nLDAC copy with the commit cycle timing.
      ldac_q        <= nldac_fall;
    end
  end

  assign or16_dac_ch0     = dac_q[0];
  assign or16_dac_ch1     = dac_q[1];
  assign or16_dac_ch2     = dac_q[2];
  assign or16_dac_ch3     = dac_q[3];
  assign or_frame_valid   = frame_valid_q;
  assign or32_frame       = frame_q;
  assign or_frame_error   = frame_error_q;
  assign or16_frame_count = frame_count_q;

endmodule

// File: tb/tb_dacx0004_spi_receiver.sv
// Self-checking bench for dacx0004_spi_receiver: drives SPI frames, keeps a
// register model, and compares each valid/error pulse against a scoreboard.
module tb_dacx0004_spi_receiver;

  logic        clk100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b1, cs = 1'b1, sdi = 1'b0, nldac = 1'b1;
  logic [15:0] ch0, ch1, ch2, ch3, fcount;
  logic        fvalid, ferror;
  logic [31:0] frame;

  dacx0004_spi_receiver dut (
    .clk100mhz        (clk100mhz),
    .rst              (rst),
    .i_sck            (sck),
    .i_cs             (cs),
    .i_sdi            (sdi),
    .i_nldac          (nldac),
    .or16_dac_ch0     (ch0),
    .or16_dac_ch1     (ch1),
    .or16_dac_ch2     (ch2),
    .or16_dac_ch3     (ch3),
    .or_frame_valid   (fvalid),
    .or32_frame       (frame),
    .or_frame_error   (ferror),
    .or16_frame_count (fcount)
  );

  always #5 clk100mhz = ~clk100mhz;

  typedef struct {
    logic             err;
    logic [31:0]      frame;
    logic [15:0]      count;
    logic [3:0][15:0] ch;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             e;
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  int               rise_cyc = 0;
  logic [3:0][15:0] in_m, dac_m;
  logic [31:0]      frame_m;
  logic [15:0]      count_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cmd, input logic [3:0] addr,
                                     input logic [15:0] data);
    return {4'h0, cmd, addr, data, 4'h0};
  endfunction

  // Reference model of one accepted frame; ldac models a coincident nLDAC fall.
  task automatic model_frame(input logic [31:0] f, input bit ldac);
    logic [3:0]  cmd = f[27:24];
    logic [3:0]  a   = f[23:20];
    logic [15:0] d   = f[19:4];
    logic [3:0]  m;
    exp_t        x;
    if (a == 4'hF)     m = 4'hF;
    else if (a < 4)    m = 4'(1 << a);
    else               m = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (cmd == 4'h0 || cmd == 4'h2 || cmd == 4'h3) in_m[i] = d;
        if (cmd == 4'h3) dac_m[i] = d;
        if (cmd == 4'h1) dac_m[i] = in_m[i];
      end
    end
    if (cmd == 4'h2 && m != 0) dac_m = in_m;
    if (ldac) dac_m = in_m;
    count_m++;
    frame_m = f;
    x.err = 1'b0; x.frame = frame_m; x.count = count_m; x.ch = dac_m;
    sb_q.push_back(x);
  endtask

  task automatic push_error();
    exp_t x;
    x.err = 1'b1; x.frame = frame_m; x.count = count_m; x.ch = dac_m;
    sb_q.push_back(x);
  endtask

  always @(posedge clk100mhz) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk100mhz) begin
    if (!rst && (fvalid || ferror)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, fvalid, ferror}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_is_error", {31'd0, ferror}, {31'd0, e.err});
        check("pulse_is_valid", {31'd0, fvalid}, {31'd0, ~e.err});
        check("pulse_latency", cyc - rise_cyc, e.err ? 32'd3 : 32'd4);
        check("frame", frame, e.frame);
        check("count", {16'd0, fcount}, {16'd0, e.count});
        check("ch0", {16'd0, ch0}, {16'd0, e.ch[0]});
        check("ch1", {16'd0, ch1}, {16'd0, e.ch[1]});
        check("ch2", {16'd0, ch2}, {16'd0, e.ch[2]});
        check("ch3", {16'd0, ch3}, {16'd0, e.ch[3]});
      end
    end
  end

  task automatic spi_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      @(negedge clk100mhz);
      sck = 1'b0;
      repeat (2) @(negedge clk100mhz);
      sck = 1'b1;
      @(negedge clk100mhz);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
      @(negedge clk100mhz);
      #1;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  task automatic spi_xfer(input logic [63:0] bits, input int n, input bit ldac);
    @(negedge clk100mhz);
    cs = 1'b0;
    repeat (3) @(negedge clk100mhz);
    spi_bits(bits, n);
    @(negedge clk100mhz);
    if (n == 32) model_frame(bits[31:0], ldac);
    else         push_error();
    if (ldac) nldac = 1'b0;
    cs = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge clk100mhz);
    nldac = 1'b1;
    drain();
    repeat (4) @(negedge clk100mhz);
  endtask

  task automatic send(input logic [3:0] cmd, input logic [3:0] addr, input logic [15:0] data);
    spi_xfer({32'd0, mk(cmd, addr, data)}, 32, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk100mhz);
    rst = 1'b0;
    in_m = '0; dac_m = '0; frame_m = '0; count_m = '0;
    sb_q.delete();
    repeat (6) @(negedge clk100mhz);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_m = '0; dac_m = '0; frame_m = '0; count_m = '0;
    do_reset();
    check("rst_ch0", {16'd0, ch0}, 32'd0);
    check("rst_ch1", {16'd0, ch1}, 32'd0);
    check("rst_ch2", {16'd0, ch2}, 32'd0);
    check("rst_ch3", {16'd0, ch3}, 32'd0);
    check("rst_frame", frame, 32'd0);
    check("rst_count", {16'd0, fcount}, 32'd0);
    check("rst_pulses", {30'd0, fvalid, ferror}, 32'd0);

    // Write-through to ch1
    send(4'h3, 4'h1, 16'hABCD);

    // Input-only write, then nLDAC copies all inputs
    send(4'h0, 4'h2, 16'h1234);
    check("ch2_before_ldac", {16'd0, ch2}, 32'd0);
    @(negedge clk100mhz);
    nldac = 1'b0;
    repeat (3) @(negedge clk100mhz);
    check("ldac_not_yet", {16'd0, ch2}, 32'd0);
    @(negedge clk100mhz);
    dac_m = in_m;
    nldac = 1'b1;
    check("ldac_ch0", {16'd0, ch0}, {16'd0, dac_m[0]});
    check("ldac_ch1", {16'd0, ch1}, {16'd0, dac_m[1]});
    check("ldac_ch2", {16'd0, ch2}, 32'h1234);
    check("ldac_ch3", {16'd0, ch3}, {16'd0, dac_m[3]});
    repeat (6) @(negedge clk100mhz);

    // Broadcast write, single update, write-and-update-all
    send(4'h0, 4'hF, 16'h5555);
    send(4'h1, 4'h0, 16'h0000);
    send(4'h2, 4'h3, 16'h7777);

    // Short and long frames are rejected
    spi_xfer({32'd0, mk(4'h3, 4'h0, 16'hDEAD)}, 31, 1'b0);
    spi_xfer({31'd0, mk(4'h3, 4'h0, 16'hBEEF), 1'b1}, 33, 1'b0);

    // Reset in the middle of a frame; nothing may be accepted afterwards
    @(negedge clk100mhz);
    cs = 1'b0;
    repeat (3) @(negedge clk100mhz);
    spi_bits({32'd0, mk(4'h3, 4'h2, 16'h9999)}, 16);
    rst = 1'b1;
    repeat (3) @(negedge clk100mhz);
    rst = 1'b0;
    in_m = '0; dac_m = '0; frame_m = '0; count_m = '0;
    sb_q.delete();
    spi_bits({48'd0, 16'hFFFF}, 16);
    repeat (3) @(negedge clk100mhz);
    cs = 1'b1;
    repeat (10) @(negedge clk100mhz);
    check("midrst_count", {16'd0, fcount}, 32'd0);
    check("midrst_ch2", {16'd0, ch2}, 32'd0);

    send(4'h3, 4'h0, 16'hFFFF);
    spi_xfer({32'd0, 32'h0800000F}, 32, 1'b0);
    spi_xfer({32'd0, 32'h05000002}, 32, 1'b0);

    // Commit coincident with an nLDAC fall
    spi_xfer({32'd0, mk(4'h0, 4'h1, 16'h2468)}, 32, 1'b1);

    // Preload the counter near its limit to reach the wrap quickly
    @(negedge clk100mhz);
    force dut.frame_count_q = 16'hFFFE;
    @(negedge clk100mhz);
    release dut.frame_count_q;
    count_m = 16'hFFFE;
    send(4'h5, 4'h0, 16'h0001);
    send(4'h5, 4'h0, 16'h0002);
    check("count_wrapped", {16'd0, fcount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
